// File: rtl/display_update_ctrl_pkg.sv
// Shared types and constants for the 7-seg refresh sequencer.
package display_update_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_START  = 2'd2,
        ST_SHIFT  = 2'd3
    } state_t;

    localparam int OVERRUN_W = 8;
    localparam logic [OVERRUN_W-1:0] OVERRUN_MAX = '1;

    function automatic logic [OVERRUN_W-1:0] sat_inc(input logic [OVERRUN_W-1:0] v);
        return (v == OVERRUN_MAX) ? v : v + {{(OVERRUN_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/display_update_ctrl_event_merge.sv
// Folds tick, load, lock edges and the idle refresh timer into one update event.
module display_update_ctrl_event_merge #(
    parameter int REFRESH_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic load_i,
    input  logic locked_i,
    input  logic idle_i,
    output logic event_o
);
    import display_update_ctrl_pkg::*;

    localparam logic [15:0] REFRESH_LAST = 16'((REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1);

    logic        r_locked_q;
    logic [15:0] r_refresh_cnt;
    logic        w_refresh_due;
    logic        w_event;

    // NOTE: r_locked_q deliberately has no reset so it tracks locked_i while
    // rst_i is held; a lock already present at release is not seen as an edge.
    always_ff @(posedge clk_i) begin
        r_locked_q <= locked_i;
    end

    assign w_refresh_due = (REFRESH_CYCLES != 0) && idle_i && (r_refresh_cnt == REFRESH_LAST);
    assign w_event       = tick_i | load_i | (locked_i ^ r_locked_q) | w_refresh_due;
    assign event_o       = w_event;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_refresh_cnt <= '0;
        end else if (!idle_i || w_event) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/display_update_ctrl.sv
// Sequences shift_reg frames: merge update events, let digits settle, start, await latch.
module display_update_ctrl #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int REFRESH_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic       locked_i,
    input  logic       latch_i,
    output logic       start_o,
    output logic       blank_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [7:0] overrun_cnt_o
);
    import display_update_ctrl_pkg::*;

    localparam logic [15:0] SETTLE_LAST  = 16'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam state_t      SETTLE_ENTRY = (SETTLE_CYCLES == 0) ? ST_START : ST_SETTLE;

    state_t                r_state;
    logic [15:0]           r_cnt;
    logic                  r_pending;
    logic                  r_blink_phase;
    logic                  r_blank;
    logic                  r_timeout;
    logic [OVERRUN_W-1:0]  r_overrun;
    logic                  w_event;
    logic                  w_idle;
    logic                  w_queue_event;

    assign w_idle = (r_state == ST_IDLE);

    display_update_ctrl_event_merge #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_event_merge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tick_i  (tick_i),
        .load_i  (load_i),
        .locked_i(locked_i),
        .idle_i  (w_idle),
        .event_o (w_event)
    );

    // Events arriving mid-frame queue into the single pending bit; the
    // latch/timeout cycle of SHIFT handles its own event below.
    assign w_queue_event = w_event &&
                           ((r_state == ST_SETTLE) || (r_state == ST_START) ||
                            ((r_state == ST_SHIFT) && !latch_i && (r_cnt != TIMEOUT_LAST)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_blink_phase <= 1'b0;
            r_blank       <= 1'b0;
            r_timeout     <= 1'b0;
            r_overrun     <= '0;
        end else begin
            r_blink_phase <= locked_i ? 1'b0 : (r_blink_phase ^ tick_i);

            if (w_queue_event) begin
                r_pending <= 1'b1;
                if (r_pending) r_overrun <= sat_inc(r_overrun);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        r_cnt   <= '0;
                        r_state <= SETTLE_ENTRY;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == SETTLE_LAST) r_state <= ST_START;
                end
                ST_START: begin
                    r_blank <= ~locked_i & r_blink_phase;
                    r_cnt   <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (latch_i) begin
                        if (r_pending || w_event) begin
                            r_cnt     <= '0;
                            r_pending <= 1'b0;
                            r_state   <= SETTLE_ENTRY;
                            if (r_pending && w_event) r_overrun <= sat_inc(r_overrun);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_timeout <= 1'b1;
                        r_pending <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start_o       = (r_state == ST_START);
    assign busy_o        = !w_idle;
    assign blank_o       = r_blank;
    assign timeout_o     = r_timeout;
    assign overrun_cnt_o = r_overrun;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed bench for display_update_ctrl: per-cycle vector table plus multi-cycle sequences.
module tb_display_update_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic       load_i;
    logic       locked_i;
    logic       latch_i;
    logic       start_o;
    logic       blank_o;
    logic       busy_o;
    logic       timeout_o;
    logic [7:0] overrun_cnt_o;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int n_starts = 0;

    typedef struct {
        logic tick;
        logic load;
        logic latch;
        logic exp_start;
        logic exp_busy;
        logic exp_blank;
    } vec_t;

    localparam int N_VEC = 34;
    vec_t vecs [N_VEC];

    always #5 clk_i = ~clk_i;

    display_update_ctrl #(
        .SETTLE_CYCLES (2),
        .TIMEOUT_CYCLES(255),
        .REFRESH_CYCLES(1000)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .load_i       (load_i),
        .locked_i     (locked_i),
        .latch_i      (latch_i),
        .start_o      (start_o),
        .blank_o      (blank_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .overrun_cnt_o(overrun_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, observe outputs at the falling edge.
    task automatic drive(input logic tk, input logic ld, input logic lt);
        @(posedge clk_i);
        #1;
        tick_i  = tk;
        load_i  = ld;
        latch_i = lt;
        @(negedge clk_i);
        cyc++;
        if (start_o === 1'b1) n_starts++;
    endtask

    task automatic wait_start(input string name, input int bound);
        int k = 0;
        while (start_o !== 1'b1 && k < bound) begin
            drive(1'b0, 1'b0, 1'b0);
            k++;
        end
        check({name, " start_o seen"}, start_o, 1);
    endtask

    // Complete a frame with a prompt latch and check the blank value it carried.
    task automatic frame(input string name, input logic exp_blank);
        wait_start(name, 150);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check({name, " idle"}, busy_o, 0);
        check({name, " blank_o"}, blank_o, exp_blank);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc;

        // Tick @10 -> start only @13, latch @20 -> idle @21; tick+load @25 -> one frame, latch @31.
        for (int i = 0; i < N_VEC; i++) begin
            vecs[i].tick      = (i == 10) || (i == 25);
            vecs[i].load      = (i == 25);
            vecs[i].latch     = (i == 20) || (i == 31);
            vecs[i].exp_start = (i == 13) || (i == 28);
            vecs[i].exp_busy  = (i >= 11 && i <= 20) || (i >= 26 && i <= 31);
            vecs[i].exp_blank = 1'b0;
        end

        rst_i    = 1'b1;
        tick_i   = 1'b0;
        load_i   = 1'b0;
        locked_i = 1'b1;
        latch_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset start_o", start_o, 0);
        check("reset busy_o", busy_o, 0);
        check("reset blank_o", blank_o, 0);
        check("reset timeout_o", timeout_o, 0);
        check("reset overrun", overrun_cnt_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i].tick, vecs[i].load, vecs[i].latch);
            check($sformatf("vec%0d start_o", i), start_o, vecs[i].exp_start);
            check($sformatf("vec%0d busy_o", i), busy_o, vecs[i].exp_busy);
            check($sformatf("vec%0d blank_o", i), blank_o, vecs[i].exp_blank);
        end
        check("merged events overrun", overrun_cnt_o, 0);

        // Two ticks in SETTLE and one in SHIFT: one re-run frame, two dropped events.
        n_starts = 0;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("pending first start", start_o, 1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("pending rerun start", start_o, 1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("pending idle", busy_o, 0);
        check("pending frames", n_starts, 2);
        check("pending overrun", overrun_cnt_o, 2);

        // Event coinciding with latch is kept and re-runs the frame.
        n_starts = 0;
        drive(1'b1, 1'b0, 1'b0);
        wait_start("latch+tick first", 10);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        wait_start("latch+tick rerun", 10);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("latch+tick idle", busy_o, 0);
        check("latch+tick frames", n_starts, 2);
        check("latch+tick overrun", overrun_cnt_o, 2);

        // No latch: abort after 255 SHIFT cycles, then a new tick still starts a frame.
        drive(1'b1, 1'b0, 1'b0);
        wait_start("timeout frame", 10);
        repeat (255) drive(1'b0, 1'b0, 1'b0);
        check("last shift busy", busy_o, 1);
        check("last shift timeout", timeout_o, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("timeout busy", busy_o, 0);
        check("timeout flag", timeout_o, 1);
        drive(1'b1, 1'b0, 1'b0);
        wait_start("after timeout", 10);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("after timeout idle", busy_o, 0);
        check("timeout sticky", timeout_o, 1);

        // Unlocked blink: lock loss frame, then ticks alternate blank 1,0,1; relock -> 0.
        locked_i = 1'b0;
        frame("unlock", 1'b0);
        for (int f = 0; f < 3; f++) begin
            repeat (90) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
            frame($sformatf("blink%0d", f), (f % 2 == 0) ? 1'b1 : 1'b0);
        end
        repeat (20) drive(1'b0, 1'b0, 1'b0);
        locked_i = 1'b1;
        frame("relock", 1'b0);

        // Self refresh: latch two cycles after start -> next start 1000+2+3 cycles later.
        wait_start("refresh first", 1100);
        s_cyc = cyc;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        wait_start("refresh second", 1100);
        check("refresh period", cyc - s_cyc, 1005);

        // Reset in the middle of SHIFT clears everything immediately.
        drive(1'b0, 1'b0, 1'b0);
        check("pre-reset busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("midreset start_o", start_o, 0);
        check("midreset busy_o", busy_o, 0);
        check("midreset blank_o", blank_o, 0);
        check("midreset timeout_o", timeout_o, 0);
        check("midreset overrun", overrun_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("post-reset idle", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
